spi_slave_core: RTL and testbench
=================================

Name: spi_slave_core

Overview:
- Parametrised SPI slave: successor to the fixed 8-bit, mode-0-only SPI block.
- Supports all four CPOL/CPHA modes, configurable word width and bit order, and back-to-back words within one chip-select frame.
- Adds input synchronisers, a valid/ready TX holding buffer, an RX valid strobe, and underrun/abort flags.
- Sits between the external SPI master pins and the register/command logic of the detector, in the system `clk` domain.

Parameters:
- WIDTH, 8: bits per word (2..32).
- CPOL, 0: idle level of mclk.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first; 0 = LSB first.
- SYNC_STAGES, 2: flop stages on mclk, mosi and cs (2..3).
- IDLE_TX, 0: WIDTH-bit word shifted out when the TX buffer is empty at a word start.

Ports:
- clk  in  1  system clock; must be at least 8x mclk frequency.
- rst  in  1  synchronous reset, active-high.
- mclk  in  1  SPI serial clock from master (asynchronous).
- mosi  in  1  serial data in (asynchronous).
- cs  in  1  chip select, active-low (high = deselected).
- miso  out  1  serial data out (registered).
- miso_oe  out  1  1 while frame active; pad tristate control.
- tx_data  in  WIDTH  word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  TX holding buffer empty.
- rx_data  out  WIDTH  last complete received word; held until the next word completes.
- rx_valid  out  1  one-cycle strobe: rx_data updated.
- busy  out  1  frame active (cs low, synchronised).
- underrun  out  1  one-cycle strobe: word start with empty TX buffer; IDLE_TX was sent.
- frame_abort  out  1  one-cycle strobe: cs deasserted with a partial word (bit count not 0).

Behaviour:
- Reset (rst high at a clk edge):
  - Synchronisers, shifters and bit counter cleared; state = WAIT_IDLE; TX buffer emptied.
  - miso, miso_oe, busy, rx_valid, underrun, frame_abort = 0; rx_data = 0.
  - tx_ready = !tx_full, so it reads 1 from the first cycle after reset. tx_valid is ignored while rst is high.
- Synchronisation and edge detection:
  - mclk, mosi and cs each pass through SYNC_STAGES flops; edges are detected against one further registered copy.
  - Leading edge = synced mclk leaves CPOL; trailing edge = it returns to CPOL.
  - Sample edge = leading if CPHA=0, else trailing; shift edge = the other one.
- TX buffer:
  - One WIDTH-bit register plus a tx_full flag; tx_ready = !tx_full.
  - Accept on tx_valid && tx_ready.
  - A load into the shifter on the same cycle as an accept takes the old buffer state: an empty buffer gives IDLE_TX + underrun, and the new word stays buffered. No bypass.
- States:
  - WAIT_IDLE: wait for synced cs = 1, then go to IDLE. This prevents joining a frame mid-stream after reset.
  - IDLE: synced cs falling edge -> ACTIVE. Clear the bit counter and load the TX shifter (buffer if full, else IDLE_TX + underrun).
    - CPHA=0: miso drives the first bit in the same cycle as the load.
    - CPHA=1: miso holds 0 until the first shift edge.
  - ACTIVE, on each sample edge: shift the synced mosi in at the end selected by MSB_FIRST and increment the counter. When the counter was WIDTH-1:
    - rx_data <= assembled word and rx_valid = 1 on the next cycle.
    - Counter wraps to 0.
    - TX shifter reloads as at frame start, for a continuous next word.
  - ACTIVE, on each shift edge: miso <= next TX bit.
    - CPHA=0: the shift edge right after the final sample edge drives bit 0 of the freshly loaded word; the first shift edge of a frame (before any sample) is ignored.
  - ACTIVE, on synced cs rising edge -> IDLE. If counter != 0: frame_abort pulse, partial RX bits discarded, loaded TX word dropped (not returned to buffer). miso = 0.
- busy and miso_oe are 1 exactly while in ACTIVE.
- Latency: pin sample edge to internal shift is SYNC_STAGES+1 clk cycles. rx_valid follows the final sample edge detection by 1 cycle.
- Simultaneous cs rise and sample edge in one cycle: cs wins; the edge is ignored.
- rx_valid has no back-pressure; the consumer must read within WIDTH mclk periods.

Test Plan:
- Mode 0, WIDTH=8, MSB_FIRST: preload tx 0xA5; master sends 0x3C -> rx_data=0x3C with one rx_valid; master captures 0xA5; underrun never asserted.
- All four modes in turn: master sends 0x96 and slave sends 0x69 -> both sides correct in every CPOL/CPHA combination.
- WIDTH=16, MSB_FIRST=0, one cs frame of two words 0x1234, 0xBEEF: buffer refilled after the first load -> two rx_valid pulses in order; miso carries both queued words with no gap.
- Empty TX buffer, IDLE_TX=0xFF: frame of 8 clocks -> underrun pulse at cs fall; master reads 0xFF; tx_ready stays 1.
- cs raised after 5 of 8 bits -> frame_abort pulse, no rx_valid, rx_data unchanged; the next full frame receives 0x55 correctly.
- rst pulsed mid-frame with cs held low -> block stays in WAIT_IDLE with busy=0 until cs rises; the following frame transfers 0xC3 correctly.

Source files
------------

// File: rtl/spi_slave_core.sv
// SPI slave core with CPOL/CPHA, width and bit-order options. It synchronises the pins into clk,
// buffers one TX word and reports receive, underrun and abort events as one-cycle strobes.
module spi_slave_core #(
   parameter int unsigned       WIDTH       = 8,
   parameter bit                CPOL        = 1'b0,
   parameter bit                CPHA        = 1'b0,
   parameter bit                MSB_FIRST   = 1'b1,
   parameter int unsigned       SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0]  IDLE_TX     = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mclk,
   input  logic             mosi,
   input  logic             cs,
   output logic             miso,
   output logic             miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             busy,
   output logic             underrun,
   output logic             frame_abort
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_WAIT_IDLE = 2'd0,
      S_IDLE      = 2'd1,
      S_ACTIVE    = 2'd2
   } state_e;

   state_e                 state_q;
   logic [SYNC_STAGES-1:0] mclk_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] cs_sync_q;
   logic                   mclk_d1_q;
   logic                   cs_d1_q;
   logic [CNT_W-1:0]       bit_cnt_q;
   logic [WIDTH-1:0]       rx_shift_q;
   logic [WIDTH-1:0]       tx_shift_q;
   logic [WIDTH-1:0]       rx_data_q;
   logic [WIDTH-1:0]       tx_buf_q;
   logic [WIDTH-1:0]       tx_buf_d;
   logic                   tx_empty_q;
   logic                   tx_empty_d;
   logic                   got_sample_q;
   logic                   miso_q;
   logic                   busy_q;
   logic                   rx_valid_q;
   logic                   underrun_q;
   logic                   frame_abort_q;

   logic                   mclk_s;
   logic                   mosi_s;
   logic                   cs_s;
   logic                   lead_edge;
   logic                   trail_edge;
   logic                   sample_edge;
   logic                   shift_edge;
   logic                   cs_fall;
   logic                   cs_rise;
   logic                   word_last;
   logic                   load_now;
   logic [WIDTH-1:0]       load_word;
   logic [WIDTH-1:0]       rx_in;

   // Bit that leaves the shifter next, honouring the bit order.
   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
      return MSB_FIRST ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
   endfunction

   assign mclk_s = mclk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];

   // Edge classification relative to the idle level of mclk.
   always_comb begin
      lead_edge   = (mclk_d1_q == CPOL) && (mclk_s != CPOL);
      trail_edge  = (mclk_d1_q != CPOL) && (mclk_s == CPOL);
      sample_edge = CPHA ? trail_edge : lead_edge;
      shift_edge  = CPHA ? lead_edge  : trail_edge;
      cs_fall     = cs_d1_q && !cs_s;
      cs_rise     = !cs_d1_q && cs_s;
      word_last   = (bit_cnt_q == CNT_W'(WIDTH - 1));
      rx_in       = shift_in(rx_shift_q, mosi_s);
   end

   // TX holding buffer: a load sees the buffer as it was before any same-cycle accept.
   always_comb begin
      load_now   = ((state_q == S_IDLE) && cs_fall) ||
                   ((state_q == S_ACTIVE) && !cs_rise && sample_edge && word_last);
      load_word  = tx_empty_q ? IDLE_TX : tx_buf_q;
      tx_empty_d = tx_empty_q;
      tx_buf_d   = tx_buf_q;
      if (load_now) begin
         tx_empty_d = 1'b1;
      end
      if (tx_valid && tx_empty_q) begin
         tx_empty_d = 1'b0;
         tx_buf_d   = tx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_WAIT_IDLE;
         mclk_sync_q   <= '0;
         mosi_sync_q   <= '0;
         cs_sync_q     <= '0;
         mclk_d1_q     <= 1'b0;
         cs_d1_q       <= 1'b0;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         rx_data_q     <= '0;
         tx_buf_q      <= '0;
         tx_empty_q    <= 1'b1;
         got_sample_q  <= 1'b0;
         miso_q        <= 1'b0;
         busy_q        <= 1'b0;
         rx_valid_q    <= 1'b0;
         underrun_q    <= 1'b0;
         frame_abort_q <= 1'b0;
      end else begin
         mclk_sync_q   <= {mclk_sync_q[SYNC_STAGES-2:0], mclk};
         mosi_sync_q   <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         cs_sync_q     <= {cs_sync_q[SYNC_STAGES-2:0], cs};
         mclk_d1_q     <= mclk_s;
         cs_d1_q       <= cs_s;
         tx_empty_q    <= tx_empty_d;
         tx_buf_q      <= tx_buf_d;
         rx_valid_q    <= 1'b0;
         frame_abort_q <= 1'b0;
         underrun_q    <= load_now && tx_empty_q;

         case (state_q)
            S_WAIT_IDLE: begin
               // Never join a frame already in progress.
               if (cs_s) begin
                  state_q <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (cs_fall) begin
                  state_q      <= S_ACTIVE;
                  busy_q       <= 1'b1;
                  bit_cnt_q    <= '0;
                  rx_shift_q   <= '0;
                  got_sample_q <= 1'b0;
                  if (!CPHA) begin
                     miso_q     <= out_bit(load_word);
                     tx_shift_q <= shift_out(load_word);
                  end else begin
                     miso_q     <= 1'b0;
                     tx_shift_q <= load_word;
                  end
               end
            end
            S_ACTIVE: begin
               if (cs_rise) begin
                  state_q    <= S_IDLE;
                  busy_q     <= 1'b0;
                  miso_q     <= 1'b0;
                  bit_cnt_q  <= '0;
                  rx_shift_q <= '0;
                  if (bit_cnt_q != '0) begin
                     frame_abort_q <= 1'b1;
                  end
               end else if (sample_edge) begin
                  got_sample_q <= 1'b1;
                  rx_shift_q   <= rx_in;
                  if (word_last) begin
                     rx_data_q  <= rx_in;
                     rx_valid_q <= 1'b1;
                     bit_cnt_q  <= '0;
                     tx_shift_q <= load_word;
                  end else begin
                     bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                  end
               end else if (shift_edge && (CPHA || got_sample_q)) begin
                  miso_q     <= out_bit(tx_shift_q);
                  tx_shift_q <= shift_out(tx_shift_q);
               end
            end
            default: begin
               state_q <= S_WAIT_IDLE;
               busy_q  <= 1'b0;
               miso_q  <= 1'b0;
            end
         endcase
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = busy_q;
   assign busy        = busy_q;
   assign tx_ready    = tx_empty_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign underrun    = underrun_q;
   assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: four 8-bit instances (one per SPI mode, IDLE_TX=0xFF) and one
// 16-bit LSB-first instance, driven by a bit-level SPI master and checked by an event scoreboard.
module tb_spi_slave_core;

   localparam int HALF = 60;
   localparam logic [1:0] K_RX  = 2'd0;
   localparam logic [1:0] K_UND = 2'd1;
   localparam logic [1:0] K_ABT = 2'd2;

   typedef struct packed {
      logic [3:0]  dut;
      logic [1:0]  kind;
      logic [31:0] data;
   } ev_t;

   logic        clk;
   logic        rst;
   logic        mclk;
   logic        mosi;
   logic [4:0]  cs_n;
   logic [4:0]  miso_w;
   logic [4:0]  oe_w;
   logic [4:0]  tx_ready_w;
   logic [4:0]  tx_valid_w;
   logic [4:0]  rx_v;
   logic [4:0]  busy_w;
   logic [4:0]  und_w;
   logic [4:0]  abt_w;
   logic [31:0] tx_data_w [5];
   logic [7:0]  rx8 [4];
   logic [15:0] rx16;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_mode
      spi_slave_core #(
         .WIDTH(8), .CPOL(g >= 2), .CPHA((g % 2) == 1), .MSB_FIRST(1'b1),
         .SYNC_STAGES(2), .IDLE_TX(8'hFF)
      ) u_dut (
         .clk(clk), .rst(rst), .mclk(mclk), .mosi(mosi), .cs(cs_n[g]),
         .miso(miso_w[g]), .miso_oe(oe_w[g]),
         .tx_data(tx_data_w[g][7:0]), .tx_valid(tx_valid_w[g]), .tx_ready(tx_ready_w[g]),
         .rx_data(rx8[g]), .rx_valid(rx_v[g]), .busy(busy_w[g]),
         .underrun(und_w[g]), .frame_abort(abt_w[g])
      );
   end

   spi_slave_core #(
      .WIDTH(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0),
      .SYNC_STAGES(2), .IDLE_TX(16'h0000)
   ) u_dut16 (
      .clk(clk), .rst(rst), .mclk(mclk), .mosi(mosi), .cs(cs_n[4]),
      .miso(miso_w[4]), .miso_oe(oe_w[4]),
      .tx_data(tx_data_w[4][15:0]), .tx_valid(tx_valid_w[4]), .tx_ready(tx_ready_w[4]),
      .rx_data(rx16), .rx_valid(rx_v[4]), .busy(busy_w[4]),
      .underrun(und_w[4]), .frame_abort(abt_w[4])
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] rx_of(input int d);
      logic [1:0] idx;
      idx = d[1:0];
      if (d == 4) return {16'd0, rx16};
      return {24'd0, rx8[idx]};
   endfunction

   task automatic push(input int d, input logic [1:0] k, input logic [31:0] v);
      exp_q.push_back('{dut: 4'(d), kind: k, data: v});
   endtask

   task automatic sb_check(input int d, input logic [1:0] k, input logic [31:0] v);
      ev_t act, e;
      act = '{dut: 4'(d), kind: k, data: v};
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_unexpected: got dut/kind/data %h, expected no event", act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            n_err++;
            $display("FAIL sb_event: got dut/kind/data %h, expected %h", act, e);
         end
      end
   endtask

   // Monitor: every strobe from any instance must match the next expected event.
   always @(negedge clk) begin
      for (int d = 0; d < 5; d++) begin
         if (rx_v[d])  sb_check(d, K_RX, rx_of(d));
         if (und_w[d]) sb_check(d, K_UND, 32'd0);
         if (abt_w[d]) sb_check(d, K_ABT, 32'd0);
      end
   end

   function automatic int bit_pos(input int i, input int w, input bit lsb);
      int p;
      p = i % w;
      return lsb ? p : (w - 1 - p);
   endfunction

   function automatic logic mbit(input int i, input int w, input bit lsb,
                                 input logic [31:0] w0, input logic [31:0] w1);
      logic [31:0] x;
      x = ((i / w) == 0) ? w0 : w1;
      return x[bit_pos(i, w, lsb)];
   endfunction

   task automatic load_tx(input int d, input logic [31:0] v);
      chk("tx_ready_before_load", 32'(tx_ready_w[d]), 32'd1);
      tx_data_w[d]  = v;
      tx_valid_w[d] = 1'b1;
      @(posedge clk);
      #1;
      tx_valid_w[d] = 1'b0;
      chk("tx_ready_after_load", 32'(tx_ready_w[d]), 32'd0);
   endtask

   // One chip-select frame of nbits clocks; captures miso at each master sample edge.
   task automatic frame(input int d, input int nbits, input logic [31:0] mw0, input logic [31:0] mw1,
                        input int refill_at, input logic [31:0] refill_word, input int rst_at,
                        output logic [31:0] cw0, output logic [31:0] cw1);
      int w;
      bit lsb, cpol, cpha;
      logic b;
      w    = (d == 4) ? 16 : 8;
      lsb  = (d == 4);
      cpol = (d == 2) || (d == 3);
      cpha = (d == 1) || (d == 3);
      cw0  = '0;
      cw1  = '0;
      mclk = cpol;
      mosi = 1'b0;
      #HALF;
      if (!cpha) mosi = mbit(0, w, lsb, mw0, mw1);
      cs_n[d] = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         if (i == refill_at) load_tx(d, refill_word);
         if (i == rst_at) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
         end
         if (i == 1 && rst_at < 0) begin
            chk("busy_in_frame", 32'(busy_w[d]), 32'd1);
            chk("miso_oe_in_frame", 32'(oe_w[d]), 32'd1);
         end
         if (rst_at >= 0 && i == rst_at + 2) begin
            chk("busy_after_rst", 32'(busy_w[d]), 32'd0);
            chk("miso_oe_after_rst", 32'(oe_w[d]), 32'd0);
         end
         #HALF;
         if (!cpha) begin
            b = miso_w[d];
            mclk = ~cpol;
            #HALF;
            mclk = cpol;
            if (i + 1 < nbits) mosi = mbit(i + 1, w, lsb, mw0, mw1);
         end else begin
            mclk = ~cpol;
            mosi = mbit(i, w, lsb, mw0, mw1);
            #HALF;
            b = miso_w[d];
            mclk = cpol;
         end
         if ((i / w) == 0) cw0[bit_pos(i, w, lsb)] = b;
         else              cw1[bit_pos(i, w, lsb)] = b;
      end
      #HALF;
      cs_n[d] = 1'b1;
      #(4 * HALF);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] c0, c1;
      rst        = 1'b1;
      cs_n       = '1;
      mclk       = 1'b0;
      mosi       = 1'b0;
      tx_valid_w = '0;
      for (int d = 0; d < 5; d++) tx_data_w[d] = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("rst_tx_ready", 32'(tx_ready_w), 32'h1F);
      chk("rst_busy", 32'(busy_w), 32'h0);
      chk("rst_miso_oe", 32'(oe_w), 32'h0);
      chk("rst_miso", 32'(miso_w), 32'h0);
      chk("rst_rx_data8", rx_of(0), 32'h0);
      chk("rst_rx_data16", rx_of(4), 32'h0);
      repeat (10) @(posedge clk);

      // Mode 0: preloaded 0xA5, refilled mid-word so the word-end reload does not underrun
      load_tx(0, 32'hA5);
      push(0, K_RX, 32'h3C);
      frame(0, 8, 32'h3C, 32'h0, 2, 32'h00, -1, c0, c1);
      chk("m0_master_rx", c0, 32'hA5);
      chk("m0_rx_data", rx_of(0), 32'h3C);
      chk("m0_tx_ready", 32'(tx_ready_w[0]), 32'd1);
      chk("m0_miso_idle", 32'(miso_w[0]), 32'd0);

      // All four modes: 0x96 in, 0x69 out; word-end reload finds an empty buffer
      for (int m = 0; m < 4; m++) begin
         load_tx(m, 32'h69);
         push(m, K_RX, 32'h96);
         push(m, K_UND, 32'h0);
         frame(m, 8, 32'h96, 32'h0, -1, 32'h0, -1, c0, c1);
         chk($sformatf("mode%0d_master_rx", m), c0, 32'h69);
         chk($sformatf("mode%0d_rx_data", m), rx_of(m), 32'h96);
      end

      // 16-bit LSB-first, two back-to-back words in one frame
      load_tx(4, 32'h1234);
      push(4, K_RX, 32'h1234);
      push(4, K_RX, 32'hBEEF);
      push(4, K_UND, 32'h0);
      frame(4, 32, 32'h1234, 32'hBEEF, 2, 32'hBEEF, -1, c0, c1);
      chk("w16_master_rx0", c0, 32'h1234);
      chk("w16_master_rx1", c1, 32'hBEEF);
      chk("w16_rx_data", rx_of(4), 32'hBEEF);

      // Empty buffer: IDLE_TX shifted out, underrun at frame start
      push(0, K_UND, 32'h0);
      push(0, K_RX, 32'h81);
      push(0, K_UND, 32'h0);
      frame(0, 8, 32'h81, 32'h0, -1, 32'h0, -1, c0, c1);
      chk("und_master_rx", c0, 32'hFF);
      chk("und_tx_ready", 32'(tx_ready_w[0]), 32'd1);

      // Abort after 5 bits, then a clean frame
      push(0, K_UND, 32'h0);
      push(0, K_ABT, 32'h0);
      frame(0, 5, 32'h00, 32'h0, -1, 32'h0, -1, c0, c1);
      chk("abort_rx_data_held", rx_of(0), 32'h81);
      push(0, K_UND, 32'h0);
      push(0, K_RX, 32'h55);
      push(0, K_UND, 32'h0);
      frame(0, 8, 32'h55, 32'h0, -1, 32'h0, -1, c0, c1);
      chk("post_abort_master_rx", c0, 32'hFF);
      chk("post_abort_rx_data", rx_of(0), 32'h55);

      // Reset mid-frame with cs low: block must sit out the rest of the frame
      push(0, K_UND, 32'h0);
      frame(0, 8, 32'hA0, 32'h0, -1, 32'h0, 3, c0, c1);
      chk("rst_frame_busy", 32'(busy_w[0]), 32'd0);
      load_tx(0, 32'h5A);
      push(0, K_RX, 32'hC3);
      push(0, K_UND, 32'h0);
      frame(0, 8, 32'hC3, 32'h0, -1, 32'h0, -1, c0, c1);
      chk("post_rst_master_rx", c0, 32'h5A);
      chk("post_rst_rx_data", rx_of(0), 32'hC3);

      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
      chk("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
